div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
- Control FSM that sequences the shift/subtract restoring-division datapath: the accumulator register, the quotient (Q) shift register, the divisor register and the subtractor.
- Accepts a start pulse and loads the operands.
- Initialises the accumulator, then runs WIDTH shift/trial-subtract iterations and reports completion.
- Sits between the top-level handshake and the datapath registers; it contains no arithmetic of its own.

Parameters:
- WIDTH, 10, operand/quotient width; equals the number of iterations.
- CNT_W, 4, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a division; sampled only in IDLE.
- sub_neg  input  1  sign bit of the current subtractor result; 1 = trial subtract negative, so restore.
- dvsr_zero  input  1  divisor operand equals zero, valid while start is high.
- dvsr_ld  output  1  load the divisor register.
- q_ld  output  1  load the dividend into Q.
- acc_init  output  1  drives the accumulator's init input: acc <= {0, Q[MSB]}.
- acc_ld  output  1  accumulator selects the subtractor result; 0 selects shifted data_in.
- q_shift  output  1  shift Q left one bit.
- q_bit  output  1  quotient bit shifted into Q[0].
- busy  output  1  high from LOAD through DONE inclusive.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse at completion.
- div_by_zero  output  1  one-cycle pulse coincident with done when the divisor was 0.
- iter  output  CNT_W  current iteration index, for debug.

Behaviour:
- States: IDLE, LOAD, INIT, ITER, DONE, ERR. The state register is updated on the rising edge of clock.
- Outputs are decoded combinationally from the state, except q_bit and acc_ld, which also depend on sub_neg.
- Reset: state = IDLE and iter = 0. All outputs are 0 except ready = 1.
- Reset has priority over all other activity, including mid-operation. The next cycle is IDLE with no partial done pulse.
- IDLE:
  - ready = 1.
  - If start = 1 and dvsr_zero = 0: go to LOAD.
  - If start = 1 and dvsr_zero = 1: go to ERR.
  - Otherwise stay in IDLE.
- LOAD:
  - dvsr_ld = 1, q_ld = 1, busy = 1.
  - Next state INIT.
- INIT:
  - acc_init = 1, busy = 1.
  - iter <= 0.
  - Next state ITER.
- ITER: each cycle busy = 1, q_shift = 1, acc_ld = ~sub_neg, q_bit = ~sub_neg.
  - This gives restoring behaviour: on a negative result the accumulator takes shifted data_in (restore) and the quotient bit is 0.
  - iter increments each cycle.
  - Exactly WIDTH ITER cycles occur (iter = 0..WIDTH-1).
  - When iter == WIDTH-1, the next state is DONE.
- DONE:
  - done = 1 and busy = 1 for one cycle.
  - No datapath strobes are asserted, so the registers hold the result.
  - Next state IDLE.
- ERR:
  - done = 1, div_by_zero = 1, busy = 1 for one cycle.
  - No datapath strobes are asserted.
  - Next state IDLE.
- Latency: start accepted at edge 0, LOAD at cycle 1, INIT at cycle 2, ITER at cycles 3..WIDTH+2, DONE at cycle WIDTH+3 (13 for WIDTH = 10).
  - Next start is accepted in the following IDLE cycle.
  - Minimum spacing between starts is WIDTH+4 cycles.
- start while busy is ignored. It is not queued and does not affect the sequence.
- start held high continuously: a new operation begins in each IDLE cycle. done pulses are spaced WIDTH+4 cycles apart.
- In any cycle at most one of {acc_init, acc_ld} and at most one of {q_ld, q_shift} is asserted. This is mutual exclusion by construction.
- iter holds its value outside ITER. It never exceeds WIDTH-1 and never wraps.
- Illegal or unused state encodings return to IDLE on the next edge.

Test Plan:
- Reset check: assert rst for 2 cycles. Required: ready = 1, busy = 0, done = 0, all strobes = 0, iter = 0.
- Nominal division: with a behavioural datapath model, dividend = 100, divisor = 7, start for 1 cycle.
  - dvsr_ld/q_ld high at cycle 1.
  - acc_init high at cycle 2.
  - q_shift high for exactly 10 cycles (3..12).
  - done pulse at cycle 13.
  - Result: Q = 14, remainder = 2.
- Restore path: dividend = 5, divisor = 9. sub_neg = 1 every iteration. Required: acc_ld = 0 and q_bit = 0 in all 10 ITER cycles; result Q = 0, remainder = 5.
- Divide by zero: start with dvsr_zero = 1. Required: ERR for one cycle, done = div_by_zero = 1 at cycle 1, no dvsr_ld/q_ld/q_shift ever asserted, ready at cycle 2.
- start during busy: pulse start at cycles 4 and 8 of a running operation. Required: no restart, done still at cycle 13, ready at cycle 14.
- Mid-operation reset: assert rst at cycle 6 (ITER). Required: next cycle IDLE, ready = 1, no done pulse; a fresh start then completes normally (100/7 gives Q = 14).

Source files
------------

// File: rtl/div_ctrl.sv
// Control sequencer for a shift/trial-subtract restoring divider: loads operands,
// seeds the accumulator, runs WIDTH iterations and signals completion.
module div_ctrl #(
   parameter int WIDTH = 10,
   parameter int CNT_W = 4
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             start,
   input  logic             sub_neg,
   input  logic             dvsr_zero,
   output logic             dvsr_ld,
   output logic             q_ld,
   output logic             acc_init,
   output logic             acc_ld,
   output logic             q_shift,
   output logic             q_bit,
   output logic             busy,
   output logic             ready,
   output logic             done,
   output logic             div_by_zero,
   output logic [CNT_W-1:0] iter
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_INIT = 3'd2,
      S_ITER = 3'd3,
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_t state;
   state_t state_nxt;

   always_ff @(posedge clock) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // iter saturates at the last index so it can never wrap or run past WIDTH-1
   always_ff @(posedge clock) begin
      if (rst) begin
         iter <= '0;
      end else if (state == S_INIT) begin
         iter <= '0;
      end else if ((state == S_ITER) && (iter != LAST_ITER)) begin
         iter <= iter + CNT_W'(1);
      end
   end

   always_comb begin
      state_nxt = S_IDLE;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = dvsr_zero ? S_ERR : S_LOAD;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_LOAD: state_nxt = S_INIT;
         S_INIT: state_nxt = S_ITER;
         S_ITER: state_nxt = (iter == LAST_ITER) ? S_DONE : S_ITER;
         S_DONE: state_nxt = S_IDLE;
         S_ERR:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // acc_ld and q_bit follow the trial subtract: a negative result restores
   always_comb begin
      dvsr_ld     = 1'b0;
      q_ld        = 1'b0;
      acc_init    = 1'b0;
      acc_ld      = 1'b0;
      q_shift     = 1'b0;
      q_bit       = 1'b0;
      busy        = 1'b0;
      ready       = 1'b0;
      done        = 1'b0;
      div_by_zero = 1'b0;
      case (state)
         S_IDLE: begin
            ready = 1'b1;
         end
         S_LOAD: begin
            busy    = 1'b1;
            dvsr_ld = 1'b1;
            q_ld    = 1'b1;
         end
         S_INIT: begin
            busy     = 1'b1;
            acc_init = 1'b1;
         end
         S_ITER: begin
            busy    = 1'b1;
            q_shift = 1'b1;
            acc_ld  = ~sub_neg;
            q_bit   = ~sub_neg;
         end
         S_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         S_ERR: begin
            busy        = 1'b1;
            done        = 1'b1;
            div_by_zero = 1'b1;
         end
         default: begin
            ready = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: a behavioural restoring-divider datapath closes the loop,
// and a cycle-schedule model checks every output on every cycle.
module tb_div_ctrl;
   localparam int WIDTH = 10;
   localparam int CNT_W = 4;

   logic clock = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic dvsr_zero = 1'b0;
   logic sub_neg;
   logic dvsr_ld, q_ld, acc_init, acc_ld, q_shift, q_bit;
   logic busy, ready, done, div_by_zero;
   logic [CNT_W-1:0] iter;

   div_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clock(clock), .rst(rst), .start(start), .sub_neg(sub_neg), .dvsr_zero(dvsr_zero),
      .dvsr_ld(dvsr_ld), .q_ld(q_ld), .acc_init(acc_init), .acc_ld(acc_ld),
      .q_shift(q_shift), .q_bit(q_bit), .busy(busy), .ready(ready), .done(done),
      .div_by_zero(div_by_zero), .iter(iter)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;
   logic chk_en = 1'b0;

   // Datapath driven by the controller's strobes
   logic [WIDTH-1:0] op_a = '0, op_b = '0;
   logic [WIDTH-1:0] dp_q = '0, dp_d = '0;
   logic [WIDTH:0]   dp_acc = '0;
   logic [WIDTH+1:0] dp_sub;

   always_comb begin
      dp_sub  = {1'b0, dp_acc} - {2'b00, dp_d};
      sub_neg = dp_sub[WIDTH+1];
   end

   always @(posedge clock) begin
      if (dvsr_ld) dp_d <= op_b;
      if (q_ld) dp_q <= op_a;
      else if (q_shift) dp_q <= {dp_q[WIDTH-2:0], q_bit};
      if (acc_init) dp_acc <= {{WIDTH{1'b0}}, dp_q[WIDTH-1]};
      else if (q_shift) dp_acc <= {(acc_ld ? dp_sub[WIDTH-1:0] : dp_acc[WIDTH-1:0]), dp_q[WIDTH-2]};
   end

   // Schedule model: m_t is the cycle number since the accepted start (0 = idle)
   int   m_t = 0;
   logic m_err = 1'b0;
   int   m_hold = 0;

   always @(posedge clock) begin
      if (rst) begin
         m_t <= 0; m_err <= 1'b0; m_hold <= 0;
      end else begin
         if (m_t >= 3 && m_t <= WIDTH + 2) m_hold <= m_t - 3;
         if (m_t == 0) begin
            if (start) begin m_t <= 1; m_err <= dvsr_zero; end
         end else if ((m_err && m_t == 1) || m_t == WIDTH + 3) begin
            m_t <= 0; m_err <= 1'b0;
         end else begin
            m_t <= m_t + 1;
         end
      end
   end

   function automatic logic [9:0] exp_out(input int t, input logic e, input logic sn);
      logic it;
      it = (t >= 3 && t <= WIDTH + 2);
      return {t == 1 && !e, t == 1 && !e, t == 2, it && !sn, it, it && !sn,
              t != 0, t == 0, (e && t == 1) || t == WIDTH + 3, e && t == 1};
   endfunction

   int cnt_dvsr = 0, cnt_qld = 0, cnt_init = 0, cnt_accld = 0, cnt_shift = 0, cnt_qbit = 0, cnt_done = 0;
   always @(negedge clock) begin
      if (chk_en) begin
         cnt_dvsr  <= cnt_dvsr + int'(dvsr_ld);
         cnt_qld   <= cnt_qld + int'(q_ld);
         cnt_init  <= cnt_init + int'(acc_init);
         cnt_accld <= cnt_accld + int'(acc_ld);
         cnt_shift <= cnt_shift + int'(q_shift);
         cnt_qbit  <= cnt_qbit + int'(q_bit);
         cnt_done  <= cnt_done + int'(done);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_loop();
      int ei;
      forever begin
         @(negedge clock);
         if (chk_en) begin
            chk("outputs", int'({dvsr_ld, q_ld, acc_init, acc_ld, q_shift, q_bit,
                                 busy, ready, done, div_by_zero}),
                int'(exp_out(m_t, m_err, sub_neg)));
            ei = (m_t >= 3 && m_t <= WIDTH + 2) ? m_t - 3 : m_hold;
            chk("iter", int'(iter), ei);
         end
      end
   endtask

   int first_ld, first_init, first_sh, last_sh, dbz_cyc;

   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int p1, input int p2, output int dcyc);
      dcyc = -1; first_ld = -1; first_init = -1; first_sh = -1; last_sh = -1; dbz_cyc = -1;
      @(posedge clock); #1;
      op_a = a; op_b = b; start = 1'b1; dvsr_zero = (b == 0);
      @(posedge clock); #1;
      start = 1'b0; dvsr_zero = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (c > 1) begin @(posedge clock); #1; end
         start = (c == p1 || c == p2);
         @(negedge clock);
         if (dvsr_ld && first_ld < 0) first_ld = c;
         if (acc_init && first_init < 0) first_init = c;
         if (q_shift) begin
            if (first_sh < 0) first_sh = c;
            last_sh = c;
         end
         if (div_by_zero) dbz_cyc = c;
         if (done) begin dcyc = c; break; end
      end
      if (dcyc < 0) chk("done_timeout", 0, 1);
      @(posedge clock); #1;
      start = 1'b0;
      @(negedge clock);
      chk("ready_after_done", int'(ready), 1);
   endtask

   int dcyc, s_dvsr, s_qld, s_shift, s_accld, s_qbit, s_done, d1, d2, n;
   logic [WIDTH-1:0] ta [6] = '{10'd1023, 10'd1023, 10'd0, 10'd777, 10'd512, 10'd300};
   logic [WIDTH-1:0] tb [6] = '{10'd1, 10'd1023, 10'd5, 10'd25, 10'd3, 10'd300};

   initial begin
      fork compare_loop(); join_none
      rst = 1'b1;
      @(posedge clock); #1;
      chk_en = 1'b1;
      @(posedge clock); #1;
      rst = 1'b0;
      @(negedge clock);
      chk("rst_ready", int'(ready), 1);
      chk("rst_busy_done", int'({busy, done, div_by_zero}), 0);
      chk("rst_strobes", int'({dvsr_ld, q_ld, acc_init, acc_ld, q_shift, q_bit}), 0);
      chk("rst_iter", int'(iter), 0);

      // Nominal 100 / 7
      s_dvsr = cnt_dvsr; s_qld = cnt_qld; s_shift = cnt_shift;
      run_op(10'd100, 10'd7, 0, 0, dcyc);
      chk("nom_done_cycle", dcyc, 13);
      chk("nom_ld_cycle", first_ld, 1);
      chk("nom_init_cycle", first_init, 2);
      chk("nom_shift_first", first_sh, 3);
      chk("nom_shift_last", last_sh, 12);
      chk("nom_shift_count", cnt_shift - s_shift, 10);
      chk("nom_ld_count", (cnt_dvsr - s_dvsr) + (cnt_qld - s_qld), 2);
      chk("nom_quotient", int'(dp_q), 14);
      chk("nom_remainder", int'(dp_acc[WIDTH:1]), 2);

      // Restore path 5 / 9
      s_accld = cnt_accld; s_qbit = cnt_qbit; s_shift = cnt_shift;
      run_op(10'd5, 10'd9, 0, 0, dcyc);
      chk("rest_done_cycle", dcyc, 13);
      chk("rest_acc_ld_count", cnt_accld - s_accld, 0);
      chk("rest_q_bit_count", cnt_qbit - s_qbit, 0);
      chk("rest_shift_count", cnt_shift - s_shift, 10);
      chk("rest_quotient", int'(dp_q), 0);
      chk("rest_remainder", int'(dp_acc[WIDTH:1]), 5);

      // Divide by zero
      s_dvsr = cnt_dvsr; s_qld = cnt_qld; s_shift = cnt_shift;
      run_op(10'd37, 10'd0, 0, 0, dcyc);
      chk("dbz_done_cycle", dcyc, 1);
      chk("dbz_flag_cycle", dbz_cyc, 1);
      chk("dbz_no_strobes", (cnt_dvsr - s_dvsr) + (cnt_qld - s_qld) + (cnt_shift - s_shift), 0);

      // start pulses while busy are ignored
      run_op(10'd100, 10'd7, 4, 8, dcyc);
      chk("busy_start_done_cycle", dcyc, 13);
      chk("busy_start_quotient", int'(dp_q), 14);

      // Assorted operands against plain arithmetic
      for (int i = 0; i < 6; i++) begin
         run_op(ta[i], tb[i], 0, 0, dcyc);
         chk("tbl_done_cycle", dcyc, 13);
         chk("tbl_quotient", int'(dp_q), int'(ta[i] / tb[i]));
         chk("tbl_remainder", int'(dp_acc[WIDTH:1]), int'(ta[i] % tb[i]));
      end

      // Reset in the middle of ITER
      @(posedge clock); #1;
      op_a = 10'd100; op_b = 10'd7; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (4) @(posedge clock);
      @(posedge clock); #1;
      rst = 1'b1;
      @(negedge clock);
      chk("midrst_in_iter", int'(q_shift), 1);
      s_done = cnt_done;
      @(posedge clock); #1;
      rst = 1'b0;
      @(negedge clock);
      chk("midrst_ready", int'(ready), 1);
      chk("midrst_busy", int'(busy), 0);
      repeat (16) @(posedge clock);
      #1;
      chk("midrst_no_done", cnt_done - s_done, 0);
      run_op(10'd100, 10'd7, 0, 0, dcyc);
      chk("midrst_redo_cycle", dcyc, 13);
      chk("midrst_redo_quotient", int'(dp_q), 14);

      // start held high: back-to-back operations
      @(posedge clock); #1;
      op_a = 10'd100; op_b = 10'd7; start = 1'b1; dvsr_zero = 1'b0;
      d1 = -1; d2 = -1;
      for (n = 0; n < 60; n++) begin
         @(negedge clock);
         if (done) begin
            if (d1 < 0) d1 = n;
            else begin d2 = n; break; end
         end
         @(posedge clock); #1;
      end
      @(posedge clock); #1;
      start = 1'b0;
      chk("held_first_done", d1, 13);
      chk("held_spacing", d2 - d1, WIDTH + 4);
      repeat (3) @(posedge clock);
      #1;
      chk("held_idle", int'(ready), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
